// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks two WIDTH-bit operands MSB-first, CHUNK bits per clock,
// stopping at the first differing chunk. Result is a held active-low one-hot {gt_n, eq_n, lt_n}.
`timescale 1ns/1ps

module seq_magnitude_comparator #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             signed_mode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [2:0]       y_o
);

    localparam int unsigned N    = WIDTH / CHUNK;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

    localparam logic [2:0] YGt   = 3'b011;
    localparam logic [2:0] YEq   = 3'b101;
    localparam logic [2:0] YLt   = 3'b110;
    localparam logic [2:0] YNone = 3'b111;

    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
        $error("seq_magnitude_comparator: WIDTH must be a non-zero multiple of CHUNK");
    end

    typedef enum logic {
        StIdle,
        StCmp
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             signed_q;
    logic [IdxW-1:0]  idx_q;
    logic             busy_q;
    logic             done_q;
    logic [2:0]       y_q;

    logic [CHUNK-1:0] a_parts [N];
    logic [CHUNK-1:0] b_parts [N];
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic             chunk_gt;
    logic             chunk_lt;
    logic             last_chunk;

    // Chunk 0 is the most significant slice.
    for (genvar g = 0; g < N; g++) begin : g_parts
        assign a_parts[g] = a_q[WIDTH-1-g*CHUNK -: CHUNK];
        assign b_parts[g] = b_q[WIDTH-1-g*CHUNK -: CHUNK];
    end

    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (idx_q == IdxW'(i)) begin
                a_chunk = a_parts[i];
                b_chunk = b_parts[i];
            end
        end
        // Flipping both sign bits maps two's-complement order onto unsigned order.
        if (signed_q && (idx_q == '0)) begin
            a_chunk[CHUNK-1] = ~a_chunk[CHUNK-1];
            b_chunk[CHUNK-1] = ~b_chunk[CHUNK-1];
        end
        chunk_gt   = a_chunk > b_chunk;
        chunk_lt   = a_chunk < b_chunk;
        last_chunk = (idx_q == LastIdx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            y_q      <= YNone;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        a_q      <= a_i;
                        b_q      <= b_i;
                        signed_q <= signed_mode_i;
                        idx_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= StCmp;
                    end
                end
                StCmp: begin
                    if (chunk_gt || chunk_lt) begin
                        y_q     <= chunk_gt ? YGt : YLt;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (last_chunk) begin
                        y_q     <= YEq;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        idx_q <= idx_q + IdxW'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign y_o    = y_q;

endmodule

// File: doc/seq_magnitude_comparator.md
# seq_magnitude_comparator

Parametrised, multi-cycle magnitude comparator that compares two WIDTH-bit operands MSB-first, CHUNK bits per clock, with a start/busy/done handshake. It supports unsigned and two's-complement modes and terminates early on the first differing chunk. The result is a registered, held 3-bit active-low one-hot code: 011 for A>B, 101 for A==B, 110 for A<B. It extends the team's 4-bit combinational comparator to wide operands that do not meet timing in a single cycle.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of CHUNK, otherwise elaboration fails.
- CHUNK, 4, bits compared per cycle; 1 ≤ CHUNK ≤ WIDTH; N = WIDTH/CHUNK chunks.

Ports:
- clk  input  1  single clock; everything is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a compare; sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement, 0 = unsigned; sampled together with start.
- a  input  WIDTH  operand A; sampled together with start.
- b  input  WIDTH  operand B; sampled together with start.
- busy  output  1  high while a compare is in progress (state CMP).
- done  output  1  one-cycle pulse; y is updated at the same edge.
- y  output  3  {GT_n, EQ_n, LT_n}: 011 = A>B, 101 = A==B, 110 = A<B, 111 = no result since reset.

## Operation
- Reset (rst_n low, asynchronous) sets state IDLE, busy=0, done=0, y=3'b111, and clears the chunk counter and operand registers.
- There are two states, IDLE and CMP.
- IDLE, start=1:
  - latch a, b and signed_mode;
  - set the chunk counter to 0, state to CMP, busy to 1.
- IDLE, start=0: stay in IDLE.
- CMP, each edge: compare chunk idx, which is bits [WIDTH-1-idx·CHUNK -: CHUNK] of the latched operands.
  - Chunks are compared as unsigned values.
  - Exception: in signed mode, for chunk 0 only, the top bit of both operands is inverted before the compare (sign correction).
- Chunks differ:
  - y <= 011 if the A chunk is greater, 110 if smaller;
  - done <= 1, busy <= 0, state IDLE (early termination).
- Chunks equal and idx == N-1: y <= 101, done <= 1, busy <= 0, state IDLE.
- Chunks equal and idx < N-1: idx <= idx+1, stay in CMP.
- start while in CMP is ignored. No queuing. Latched operands and mode are unaffected.
- Changes on a, b or signed_mode after the start edge have no effect on the running compare.
- y holds its last result until the next done. It returns to 111 only on reset.
- CHUNK == WIDTH degenerates to a single-cycle compare through the same FSM.

## Timing
- Let E0 be the edge that samples start in IDLE. busy is high from E0 until edge Ek.
- k is the 1-based index of the first differing chunk, or k = N if the operands are equal.
- done is high for exactly the one cycle following Ek. y is valid from Ek.
- Latency is k cycles (start edge to done edge): minimum 1, maximum N.
- In the cycle where done=1, the FSM is already in IDLE and start is accepted. The back-to-back period is therefore k+1 cycles.
- Reset asserted mid-compare aborts immediately:
  - no done pulse;
  - y = 111;
  - after rst_n rises, the first rising edge can already accept start.
- rst_n low overrides start on any edge.
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan
- WIDTH=16, CHUNK=4, unsigned, a=0x1234, b=0x1234, start for 1 cycle -> busy for 4 cycles, done at E4, y=101.
- a=0x8000, b=0x7FFF -> unsigned: done at E1, y=011. signed: done at E1, y=110. Repeat with a=0xFFFF, b=0xFFFE signed -> done at E4, y=011.
- a=0x12A4, b=0x1294, unsigned -> done at E3, y=011. Swap the operands -> done at E3, y=110. y holds between compares.
- Start a compare of 0x0001 vs 0x0002 (done expected at E4). At E1 and E2, pulse start with a=0xFFFF, b=0 -> ignored; done at E4 with y=110.
- Reset: start an equal compare, pull rst_n low at E2 -> busy=0, done=0, y=111 immediately, and no done pulse follows. After release, a=0x0010, b=0x0001 -> done at E3, y=011.
- Back-to-back: assert start in the done cycle with new operands -> accepted, second done after its own k cycles. Also run WIDTH=8, CHUNK=8 and WIDTH=4, CHUNK=1, checking random operands against a reference model for both modes.
